// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ sources.
// Issues one byte per frame, confirms via TxBusy, acks, waits for frame end.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            Req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] ReqData,
  input  logic [NUM_REQ-1:0]            ReqParityEn,
  output logic [NUM_REQ-1:0]            Ack,
  input  logic                          TxBusy,
  output logic                          TxDataValid,
  output logic [DATA_WIDTH-1:0]         TxData,
  output logic                          TxParityEn,
  output logic [$clog2(NUM_REQ)-1:0]    ActiveId,
  output logic                          ErrTimeout
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t                r_state;
  logic [IDW-1:0]        r_ptr;
  logic [CW-1:0]         r_cnt;
  logic [NUM_REQ-1:0]    r_ack;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_par;
  logic [IDW-1:0]        r_id;
  logic                  r_err;

  logic [IDW:0]          w_sum;
  logic [IDW-1:0]        w_cand;
  logic [IDW-1:0]        w_win;
  logic                  w_found;
  logic [DATA_WIDTH-1:0] w_data;
  logic [IDW-1:0]        w_next_ptr;

  // First set request searching upward from the pointer, with wrap.
  // Walking offsets high-to-low lets the lowest offset win last.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    w_cand  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_sum = {1'b0, r_ptr} + (IDW+1)'(i);
      if (w_sum >= (IDW+1)'(NUM_REQ))
        w_sum = w_sum - (IDW+1)'(NUM_REQ);
      w_cand = w_sum[IDW-1:0];
      if (Req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  // Byte mux for the selected requester.
  always_comb begin
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDW'(i) == w_win)
        w_data = ReqData[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign w_next_ptr = (r_id == IDW'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;

  // Frame FSM: select, pulse DataValid, confirm busy, wait for frame end.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_ack   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_par   <= 1'b0;
      r_id    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ack   <= '0;
      r_err   <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (!TxBusy && w_found) begin
            r_data  <= w_data;
            r_par   <= ReqParityEn[w_win];
            r_id    <= w_win;
            r_valid <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= '0;
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          // Busy takes priority over a coincident terminal count.
          if (TxBusy) begin
            r_ack   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << r_id;
            r_ptr   <= w_next_ptr;
            r_state <= S_WAIT_DONE;
          end else if (r_cnt == CW'(BUSY_TIMEOUT - 1)) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!TxBusy)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Ack         = r_ack;
  assign TxDataValid = r_valid;
  assign TxData      = r_data;
  assign TxParityEn  = r_par;
  assign ActiveId    = r_id;
  assign ErrTimeout  = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a transmitter model
// and an expected-frame scoreboard.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int TO   = 4;
  localparam int HOLD = 11;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [N-1:0]  Req = '0;
  logic [N*DW-1:0] ReqData = '0;
  logic [N-1:0]  ReqParityEn = '0;
  logic [N-1:0]  Ack;
  logic          TxBusy;
  logic          TxDataValid;
  logic [DW-1:0] TxData;
  logic          TxParityEn;
  logic [1:0]    ActiveId;
  logic          ErrTimeout;

  always #5 CLK = ~CLK;

  uart_tx_arbiter #(
    .NUM_REQ(N),
    .DATA_WIDTH(DW),
    .BUSY_TIMEOUT(TO)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .Req(Req),
    .ReqData(ReqData),
    .ReqParityEn(ReqParityEn),
    .Ack(Ack),
    .TxBusy(TxBusy),
    .TxDataValid(TxDataValid),
    .TxData(TxData),
    .TxParityEn(TxParityEn),
    .ActiveId(ActiveId),
    .ErrTimeout(ErrTimeout)
  );

  // Transmitter model: Busy rises the cycle after DataValid, held HOLD cycles.
  logic m_busy = 1'b0;
  int   m_cnt  = 0;
  bit   m_on   = 1'b1;

  always @(posedge CLK) begin
    if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_busy <= 1'b0;
    end else if (m_on && TxDataValid && !m_busy) begin
      m_busy <= 1'b1;
      m_cnt  <= HOLD;
    end
  end
  assign TxBusy = m_busy;

  typedef struct {
    int          id;
    logic [7:0]  d;
    logic        p;
    bit          ack;
  } exp_t;

  exp_t q[$];
  exp_t aq[$];
  exp_t cur;

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;
  int valid_cyc = -100;
  int ack_cyc   = -100;
  int err_cyc   = -100;
  int fall_cyc  = -100;
  bit prev_busy = 1'b0;
  bit drop_on_ack = 1'b1;
  bit gap_chk = 1'b0;
  bit err_ok  = 1'b0;
  bit cur_valid = 1'b0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push(int id, logic [7:0] d, logic p, bit ack);
    exp_t e;
    e.id = id; e.d = d; e.p = p; e.ack = ack;
    q.push_back(e);
  endfunction

  task automatic cyc();
    exp_t e;
    @(posedge CLK);
    #1;
    ncyc++;
    if (prev_busy && !TxBusy) fall_cyc = ncyc;
    prev_busy = TxBusy;
    if (RST) return;
    if (TxDataValid === 1'b1) begin
      if (q.size() == 0) begin
        check("valid_unexp", 32'(TxDataValid), 0);
      end else begin
        e = q.pop_front();
        check("data", 32'(TxData), 32'(e.d));
        check("par", 32'(TxParityEn), 32'(e.p));
        check("id", 32'(ActiveId), e.id);
        if (gap_chk && fall_cyc > valid_cyc)
          check("gap", ncyc - fall_cyc, 2);
        valid_cyc = ncyc;
        cur = e;
        cur_valid = 1'b1;
        if (e.ack) aq.push_back(e);
      end
    end
    if (Ack !== '0) begin
      if (aq.size() == 0) begin
        check("ack_unexp", 32'(Ack), 0);
      end else begin
        e = aq.pop_front();
        check("ack", 32'(Ack), 32'(1) << e.id);
        check("ack_lat", ncyc - valid_cyc, 2);
        ack_cyc = ncyc;
        if (drop_on_ack) Req = Req & ~Ack;
      end
    end
    if (ErrTimeout === 1'b1) begin
      err_cyc = ncyc;
      cur_valid = 1'b0;
      if (!err_ok) check("err_unexp", 32'(ErrTimeout), 0);
    end
    if (cur_valid && TxBusy) begin
      check("hold_data", 32'(TxData), 32'(cur.d));
      check("hold_par", 32'(TxParityEn), 32'(cur.p));
      check("hold_id", 32'(ActiveId), cur.id);
    end
  endtask

  task automatic drain(string tag, int budget);
    int n;
    n = 0;
    while ((q.size() != 0 || aq.size() != 0 || TxBusy) && n < budget) begin
      cyc();
      n++;
    end
    check({tag, "_drain"}, 32'(n < budget), 1);
    cyc();
    cyc();
  endtask

  task automatic chk_zero(string tag);
    check({tag, "_ack"}, 32'(Ack), 0);
    check({tag, "_valid"}, 32'(TxDataValid), 0);
    check({tag, "_data"}, 32'(TxData), 0);
    check({tag, "_par"}, 32'(TxParityEn), 0);
    check({tag, "_id"}, 32'(ActiveId), 0);
    check({tag, "_err"}, 32'(ErrTimeout), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    int req_cyc;
    int rst_cyc;
    int n;
    int start_err;
    int first_v;
    int d;

    // Reset state
    RST = 1'b1;
    cyc();
    cyc();
    chk_zero("reset");
    RST = 1'b0;

    // Single request from requester 1
    ReqData[1*DW +: DW] = 8'hA5;
    ReqParityEn = 4'b0010;
    Req = 4'b0010;
    req_cyc = ncyc;
    push(1, 8'hA5, 1'b1, 1'b1);
    drain("single", 60);
    check("single_lat", valid_cyc - req_cyc, 1);
    repeat (15) cyc();
    check("single_reqdrop", 32'(Req), 0);

    // Round-robin with all requests held, from pointer 0
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    cur_valid = 1'b0;
    ReqParityEn = '0;
    for (int i = 0; i < N; i++) ReqData[i*DW +: DW] = 8'h10 + 8'(i);
    drop_on_ack = 1'b0;
    Req = 4'b1111;
    push(0, 8'h10, 1'b0, 1'b1);
    push(1, 8'h11, 1'b0, 1'b1);
    push(2, 8'h12, 1'b0, 1'b1);
    push(3, 8'h13, 1'b0, 1'b1);
    push(0, 8'h10, 1'b0, 1'b1);
    n = 0;
    while (q.size() != 0 && n < 300) begin
      cyc();
      n++;
      if (q.size() <= 4) gap_chk = 1'b1;
    end
    Req = '0;
    gap_chk = 1'b0;
    drop_on_ack = 1'b1;
    check("rr_done", q.size(), 0);
    drain("rr", 60);

    // Wrap: grant 2 leaves pointer at 3, then 0 wins before 2
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    cur_valid = 1'b0;
    for (int i = 0; i < N; i++) ReqData[i*DW +: DW] = 8'h20 + 8'(i);
    Req = 4'b0100;
    push(2, 8'h22, 1'b0, 1'b1);
    drain("wrap_a", 60);
    Req = 4'b0101;
    push(0, 8'h20, 1'b0, 1'b1);
    push(2, 8'h22, 1'b0, 1'b1);
    drain("wrap_b", 120);

    // Timeout: transmitter never goes busy, then retry succeeds
    m_on = 1'b0;
    err_ok = 1'b1;
    ReqData[0 +: DW] = 8'h55;
    Req = 4'b0001;
    push(0, 8'h55, 1'b0, 1'b0);
    push(0, 8'h55, 1'b0, 1'b1);
    start_err = err_cyc;
    n = 0;
    while (err_cyc == start_err && n < 40) begin
      cyc();
      n++;
    end
    first_v = valid_cyc;
    check("to_seen", 32'(err_cyc != start_err), 1);
    check("to_delay", err_cyc - first_v, TO + 1);
    m_on = 1'b1;
    err_ok = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 10) begin
      cyc();
      n++;
    end
    d = valid_cyc - err_cyc;
    check("retry_gap", 32'(d >= 1 && d <= 2), 1);
    drain("retry", 60);

    // Reset during WAIT_DONE, then issue gated by Busy
    ReqData[0 +: DW] = 8'h66;
    Req = 4'b0001;
    push(0, 8'h66, 1'b0, 1'b1);
    n = 0;
    while ((q.size() != 0 || aq.size() != 0) && n < 20) begin
      cyc();
      n++;
    end
    cyc();
    cyc();
    check("rst_busy_pre", 32'(TxBusy), 1);
    RST = 1'b1;
    rst_cyc = ncyc;
    cyc();
    chk_zero("midrst");
    RST = 1'b0;
    cur_valid = 1'b0;
    ReqData[0 +: DW] = 8'h77;
    Req = 4'b0001;
    push(0, 8'h77, 1'b0, 1'b1);
    n = 0;
    while (q.size() != 0 && n < 40) begin
      cyc();
      n++;
    end
    check("rst_fell", 32'(fall_cyc > rst_cyc), 1);
    check("rst_gate", valid_cyc - fall_cyc, 1);
    drain("rst", 60);

    // Per-frame parity, alternating owners 0 and 1
    ReqParityEn = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      ReqData[(k % 2)*DW +: DW] = 8'h30 + 8'(k);
      Req = 4'(1) << (k % 2);
      push(k % 2, 8'h30 + 8'(k), 1'(k % 2), 1'b1);
      drain("parity", 60);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
